ram_refresh_sched: RTL and testbench

//  Refresh scheduler for the DRAM controller's refresh-counter interface; drives its RefReqIn/RefUrgentIn.

---
 rtl/ram_refresh_sched_if.sv | 35 +++
 rtl/ram_refresh_sched.sv | 159 +++++++++++++++
 tb/tb_ram_refresh_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ram_refresh_sched_if.sv
// Refresh scheduler <-> DRAM controller refresh-counter interface.
// The scheduler uses the slave modport. The controller side, or a bench,
// uses the master modport.
// The holdoff signal exists only when REFSCHED_HOLDOFF_EN is defined.
interface ram_refresh_sched_if #(
  parameter int DEBT_W = 3
);
  logic              en;          // timer enable
  logic              ref_ack;     // one-clock refresh-issued pulse
  logic              ref_req;     // refresh request
  logic              ref_urgent;  // urgent refresh request
  logic [DEBT_W-1:0] debt;        // outstanding refreshes
  logic              overflow;    // sticky debt overflow
`ifdef REFSCHED_HOLDOFF_EN
  logic              holdoff;     // mask non-urgent requests

  modport master (
    output en, ref_ack, holdoff,
    input  ref_req, ref_urgent, debt, overflow
  );
  modport slave (
    input  en, ref_ack, holdoff,
    output ref_req, ref_urgent, debt, overflow
  );
`else
  modport master (
    output en, ref_ack,
    input  ref_req, ref_urgent, debt, overflow
  );
  modport slave (
    input  en, ref_ack,
    output ref_req, ref_urgent, debt, overflow
  );
`endif
endinterface

// File: rtl/ram_refresh_sched.sv
// ram_refresh_sched
// A periodic timer accrues refresh debt, and every acknowledged refresh
// retires one unit of that debt.
// A request becomes urgent once the debt reaches URG_TH. After each ack,
// the request is held low for GAP clocks, which lets the controller's
// done latch clear.
// Optional feature macro: REFSCHED_HOLDOFF_EN (adds a holdoff input that
// masks non-urgent requests).
module ram_refresh_sched #(
  parameter int PERIOD   = 390,
  parameter int DEBT_W   = 3,
  parameter int DEBT_MAX = 7,
  parameter int URG_TH   = 2,
  parameter int GAP      = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  ram_refresh_sched_if.slave  bus
);

  localparam int TMR_W = $clog2(PERIOD);
  localparam int GAP_W = $clog2(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [DEBT_W-1:0]  r_debt;
  logic [DEBT_W-1:0]  w_debt_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               r_req;
  logic               r_urg;
  logic               r_ovf;
  logic               w_req_d;
  logic               w_urg_d;
  logic               w_ovf_set;
  logic               w_tick;
  logic               w_ack;
  logic               w_mask;

  // Slot tick is produced when the running timer reaches zero.
  assign w_tick = bus.en && (r_timer == TMR_W'(0));
  // Only acks that answer an outstanding request are counted.
  assign w_ack  = bus.ref_ack && (r_state == S_REQ);

`ifdef REFSCHED_HOLDOFF_EN
  assign w_mask = bus.holdoff;
`else
  assign w_mask = 1'b0;
`endif

  // Slot timer: counts down while enabled and reloads after each tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= TMR_W'(PERIOD - 1);
    end else if (w_tick) begin
      r_timer <= TMR_W'(PERIOD - 1);
    end else if (bus.en) begin
      r_timer <= r_timer - TMR_W'(1);
    end else begin
      r_timer <= r_timer;
    end
  end

  // Debt bookkeeping: a tick adds debt and an ack retires it. When both
  // occur together they cancel. Debt saturates instead of wrapping.
  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_set  = 1'b0;
    if (w_tick && !w_ack) begin
      if (r_debt == DEBT_W'(DEBT_MAX)) begin
        w_ovf_set = 1'b1;
      end else begin
        w_debt_nxt = r_debt + DEBT_W'(1);
      end
    end else if (w_ack && !w_tick) begin
      w_debt_nxt = r_debt - DEBT_W'(1);
    end else begin
      w_debt_nxt = r_debt;
    end
  end

  // Request FSM: next state, gap counter and next registered outputs.
  // The request drops on the ack edge itself. GAP state leaves when the
  // counter decrements to zero, so the request stays low for exactly GAP
  // clocks.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_req_d     = 1'b0;
    w_urg_d     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_debt_nxt != DEBT_W'(0)) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_W'(GAP - 1);
        end else begin
          w_urg_d = (w_debt_nxt >= DEBT_W'(URG_TH));
          // A holdoff masks only non-urgent requests.
          w_req_d = !(w_mask && !w_urg_d);
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt == GAP_W'(1)) begin
          if (w_debt_nxt != DEBT_W'(0)) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gap_nxt   = GAP_W'(0);
      end
    endcase
  end

  // State, debt, gap counter and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_debt    <= DEBT_W'(0);
      r_gap_cnt <= GAP_W'(0);
      r_req     <= 1'b0;
      r_urg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_debt    <= w_debt_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_req     <= w_req_d;
      r_urg     <= w_urg_d;
      r_ovf     <= r_ovf | w_ovf_set;
    end
  end

  assign bus.ref_req    = r_req;
  assign bus.ref_urgent = r_urg;
  assign bus.debt       = r_debt;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Directed bench for ram_refresh_sched, configured with PERIOD=8,
// DEBT_MAX=7, URG_TH=2 and GAP=3.
// Edge numbers in the comments count posedges after reset release.
// Edge 1 is the first posedge after release.
module tb_ram_refresh_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ram_refresh_sched_if #(.DEBT_W(3)) bus ();

  ram_refresh_sched #(
    .PERIOD(8), .DEBT_W(3), .DEBT_MAX(7), .URG_TH(2), .GAP(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n posedges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset, then release it just after a negedge.
  task automatic do_reset();
    rst = 1'b1;
    bus.ref_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.en      = 1'b1;
    bus.ref_ack = 1'b0;
`ifdef REFSCHED_HOLDOFF_EN
    bus.holdoff = 1'b0;
`endif
    @(negedge clk);
    check("rst_req", bus.ref_req, 0);
    check("rst_urg", bus.ref_urgent, 0);
    check("rst_debt", bus.debt, 0);
    check("rst_ovf", bus.overflow, 0);

    // Scenario 1: accrue debt with no acks until the debt overflows.
    do_reset();
    step(7);   // edge 7
    check("pre_tick_debt", bus.debt, 0);
    step(1);   // edge 8: first tick
    check("tick1_debt", bus.debt, 1);
    check("tick1_req_lat", bus.ref_req, 0);
    step(1);   // edge 9
    check("req_on", bus.ref_req, 1);
    check("req_not_urg", bus.ref_urgent, 0);
    step(8);   // edge 17
    check("tick2_debt", bus.debt, 2);
    check("urg_on", bus.ref_urgent, 1);
    step(39);  // edge 56: seventh tick
    check("sat_debt", bus.debt, 7);
    check("sat_no_ovf", bus.overflow, 0);
    step(8);   // edge 64: eighth tick
    check("ovf_set", bus.overflow, 1);
    check("ovf_debt", bus.debt, 7);
    check("ovf_req", bus.ref_req, 1);
    // An asynchronous reset during REQ drops the request immediately.
    rst = 1'b1;
    #1;
    check("async_rst_req", bus.ref_req, 0);
    check("async_rst_ovf", bus.overflow, 0);
    check("async_rst_debt", bus.debt, 0);

    // Scenario 2: acks, the gap, a tick coincident with an ack, ignored
    // acks and the enable hold.
    do_reset();
    step(17);  // edge 17: REQ, debt 2
    check("s2_urg", bus.ref_urgent, 1);
    bus.ref_ack = 1'b1;
    step(1);   // edge 18: ack accepted
    bus.ref_ack = 1'b0;
    check("ack_debt", bus.debt, 1);
    check("gap1_req", bus.ref_req, 0);
    check("gap1_urg", bus.ref_urgent, 0);
    step(1);   // edge 19
    check("gap2_req", bus.ref_req, 0);
    bus.ref_ack = 1'b1;  // lands during GAP and must be ignored
    step(1);   // edge 20
    bus.ref_ack = 1'b0;
    check("gap3_req", bus.ref_req, 0);
    check("gap_ack_ignored", bus.debt, 1);
    step(1);   // edge 21
    check("post_gap_req", bus.ref_req, 1);
    check("post_gap_urg", bus.ref_urgent, 0);
    check("post_gap_debt", bus.debt, 1);
    step(3);   // edge 24: tick, debt 2
    bus.ref_ack = 1'b1;
    step(1);   // edge 25
    bus.ref_ack = 1'b0;
    check("ack2_debt", bus.debt, 1);
    step(6);   // edge 31: REQ again
    bus.ref_ack = 1'b1;
    step(1);   // edge 32: ack coincides with tick
    bus.ref_ack = 1'b0;
    check("ack_tick_debt", bus.debt, 1);
    check("ack_tick_req", bus.ref_req, 0);
    step(2);   // edge 34
    check("ack_tick_gap_req", bus.ref_req, 0);
    step(1);   // edge 35
    check("ack_tick_rereq", bus.ref_req, 1);
    bus.ref_ack = 1'b1;
    step(1);   // edge 36: debt reaches zero
    bus.ref_ack = 1'b0;
    bus.en = 1'b0;
    check("clear_debt", bus.debt, 0);
    step(8);   // edge 44: IDLE
    bus.ref_ack = 1'b1;
    step(1);   // edge 45: ack in IDLE must be ignored
    bus.ref_ack = 1'b0;
    check("idle_ack_debt", bus.debt, 0);
    check("idle_ack_req", bus.ref_req, 0);
    step(11);  // edge 56: 20 clocks with the timer frozen
    check("en0_debt", bus.debt, 0);
    check("en0_req", bus.ref_req, 0);
    bus.en = 1'b1;
    step(3);   // edge 59: timer resumes from its held value of 3
    check("resume_debt", bus.debt, 0);
    step(1);   // edge 60
    check("resume_tick", bus.debt, 1);
    step(1);   // edge 61
    check("resume_req", bus.ref_req, 1);

`ifdef REFSCHED_HOLDOFF_EN
    // Holdoff masks a non-urgent request but never an urgent one.
    bus.holdoff = 1'b1;
    do_reset();
    step(9);   // edge 9: debt 1, masked
    check("hold_debt", bus.debt, 1);
    check("hold_masked", bus.ref_req, 0);
    step(8);   // edge 17: debt 2, urgent
    check("hold_urg_req", bus.ref_req, 1);
    check("hold_urg", bus.ref_urgent, 1);
    bus.holdoff = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
